// File: rtl/fp_round_pipe.sv
// Two-stage IEEE-754 rounding pipeline: S1 registers the operand and its increment
// decision, S2 registers the rounded and renormalised result, with valid/ready flow control.
module fp_round_pipe #(
   parameter int MAN_W = 24,
   parameter int EXP_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [MAN_W+1:0] in_man,
   input  logic             in_sticky,
   input  logic [2:0]       in_rmode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [EXP_W-1:0] out_exp,
   output logic [MAN_W-1:0] out_man,
   output logic             out_overflow,
   output logic             out_inexact
);

   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RUP = 3'd2;
   localparam logic [2:0] RM_RDN = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   function automatic logic round_inc(input logic       sign,
                                      input logic [2:0] rmode,
                                      input logic       l,
                                      input logic       g,
                                      input logic       x);
      logic inc;
      case (rmode)
         RM_RTZ:  inc = 1'b0;
         RM_RUP:  inc = ~sign & (g | x);
         RM_RDN:  inc = sign & (g | x);
         RM_RMM:  inc = g;
         default: inc = g & (l | x);
      endcase
      return inc;
   endfunction

   // Returns {overflow, exponent, significand}; a carry-out renormalises to 1.000..
   // and an all-ones exponent collapses the significand to infinity.
   function automatic logic [EXP_W+MAN_W:0] renorm(input logic [EXP_W-1:0] exp,
                                                  input logic [MAN_W-1:0] man,
                                                  input logic             inc);
      logic [MAN_W:0]   sum;
      logic [EXP_W-1:0] exp_r;
      logic [MAN_W-1:0] man_r;
      logic             ovf;
      sum = {1'b0, man} + {{MAN_W{1'b0}}, inc};
      if (sum[MAN_W]) begin
         man_r = {1'b1, {(MAN_W-1){1'b0}}};
         exp_r = exp + {{(EXP_W-1){1'b0}}, 1'b1};
      end else begin
         man_r = sum[MAN_W-1:0];
         exp_r = exp;
      end
      ovf = &exp_r;
      if (ovf)
         man_r = '0;
      return {ovf, exp_r, man_r};
   endfunction

   logic                   rdy_en_p0;
   logic                   inc_p0;
   logic                   inx_p0;
   logic                   s1_load;
   logic                   s2_load;

   logic                   vld_p1;
   logic                   sign_p1;
   logic                   inc_p1;
   logic                   inx_p1;
   logic [EXP_W-1:0]       exp_p1;
   logic [MAN_W-1:0]       man_p1;
   logic [EXP_W+MAN_W:0]   rn_p1;

   logic                   vld_p2;
   logic                   sign_p2;
   logic                   ovf_p2;
   logic                   inx_p2;
   logic [EXP_W-1:0]       exp_p2;
   logic [MAN_W-1:0]       man_p2;

   assign s2_load  = vld_p1 & (~vld_p2 | out_ready);
   assign in_ready = rdy_en_p0 & (~vld_p1 | s2_load);
   assign s1_load  = in_valid & in_ready;

   assign inc_p0 = round_inc(in_sign, in_rmode, in_man[2], in_man[1], in_man[0] | in_sticky);
   assign inx_p0 = in_man[1] | in_man[0] | in_sticky;

   // Holds in_ready low for the first cycle after reset release.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         rdy_en_p0 <= 1'b0;
      else
         rdy_en_p0 <= 1'b1;
   end

   // ---- Stage 1: operand capture and increment decision ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         vld_p1  <= 1'b0;
         sign_p1 <= 1'b0;
         inc_p1  <= 1'b0;
         inx_p1  <= 1'b0;
         exp_p1  <= '0;
         man_p1  <= '0;
      end else begin
         vld_p1 <= s1_load | (vld_p1 & ~s2_load);
         if (s1_load) begin
            sign_p1 <= in_sign;
            inc_p1  <= inc_p0;
            inx_p1  <= inx_p0;
            exp_p1  <= in_exp;
            man_p1  <= in_man[MAN_W+1:2];
         end
      end
   end

   assign rn_p1 = renorm(exp_p1, man_p1, inc_p1);

   // ---- Stage 2: rounded, renormalised result ----
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         vld_p2  <= 1'b0;
         sign_p2 <= 1'b0;
         ovf_p2  <= 1'b0;
         inx_p2  <= 1'b0;
         exp_p2  <= '0;
         man_p2  <= '0;
      end else begin
         vld_p2 <= s2_load | (vld_p2 & ~out_ready);
         if (s2_load) begin
            sign_p2 <= sign_p1;
            ovf_p2  <= rn_p1[EXP_W+MAN_W];
            exp_p2  <= rn_p1[EXP_W+MAN_W-1:MAN_W];
            man_p2  <= rn_p1[MAN_W-1:0];
            inx_p2  <= inx_p1 | rn_p1[EXP_W+MAN_W];
         end
      end
   end

   assign out_valid    = vld_p2;
   assign out_sign     = sign_p2;
   assign out_exp      = exp_p2;
   assign out_man      = man_p2;
   assign out_overflow = ovf_p2;
   assign out_inexact  = inx_p2;

endmodule
